// File: rtl/ps2_pkg.sv
// PS/2 receive controller shared types: FSM states, error codes, frame geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int FRAME_DATA_BITS = 8;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Saturating silence counter; terminal count flags the last cycle before a frame times out.
// Latency: o_tc is a decode of the count register (0 cycles from the count).
// Backpressure: none; clear has priority over enable.
module ps2_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Count reaches TIMEOUT_CYCLES-1 in the cycle whose closing edge completes
    // TIMEOUT_CYCLES silent cycles after the clearing pulse edge.
    localparam logic [CW-1:0] TC_VAL  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT_VAL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    // Count silent cycles, holding at the saturation value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != SAT_VAL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first, odd parity, stop, with silence timeout.
// Latency: byte/strobes/error code registered 1 cycle after the stop-bit (or timeout) cycle.
// Backpressure: none; each received byte is a one-cycle strobe and must be taken immediately.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pulse_i,
    input  logic       data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       busy_o
);

    localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity_ok;
    logic [7:0] r_byte;
    logic       r_valid;
    logic       r_err;
    logic [1:0] r_err_code;

    logic       w_busy;
    logic       w_tc;
    logic       w_timeout;
    logic       w_load;
    logic       w_err_set;
    logic [1:0] w_code_nxt;

    assign w_busy = (r_state != IDLE);
    // A pulse on the terminal-count cycle keeps the frame alive.
    assign w_timeout = w_busy && w_tc && !pulse_i;

    ps2_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (clk_i),
        .i_rst    (reset_i),
        .i_clear  (pulse_i || !w_busy),
        .i_enable (w_busy),
        .o_tc     (w_tc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: advance on pulses, abandon the frame on timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (pulse_i && !data_i) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (w_timeout)                             w_state_nxt = IDLE;
                else if (pulse_i && (r_bit_cnt == LAST_BIT)) w_state_nxt = PARITY;
            end
            PARITY: begin
                if (w_timeout)    w_state_nxt = IDLE;
                else if (pulse_i) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_timeout || pulse_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: frame verdict at the stop bit; framing beats parity.
    always_comb begin
        w_load     = 1'b0;
        w_err_set  = 1'b0;
        w_code_nxt = r_err_code;
        if ((r_state == STOP) && pulse_i) begin
            if (!data_i) begin
                w_err_set  = 1'b1;
                w_code_nxt = ERR_FRAME;
            end else if (!r_parity_ok) begin
                w_err_set  = 1'b1;
                w_code_nxt = ERR_PARITY;
            end else begin
                w_load     = 1'b1;
                w_code_nxt = ERR_NONE;
            end
        end else if (w_timeout) begin
            w_err_set  = 1'b1;
            w_code_nxt = ERR_TIMEOUT;
        end
    end

    // Datapath: shift register, bit counter, parity latch and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity_ok <= 1'b0;
            r_byte      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_valid    <= w_load;
            r_err      <= w_err_set;
            r_err_code <= w_code_nxt;
            if (w_load) r_byte <= r_shift;
            if ((r_state == IDLE) && pulse_i && !data_i) r_bit_cnt <= '0;
            if ((r_state == SHIFT) && pulse_i) begin
                r_shift   <= {data_i, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // Odd parity: data bits plus parity bit must hold an odd count of ones.
            if ((r_state == PARITY) && pulse_i) r_parity_ok <= ^{r_shift, data_i};
        end
    end

    assign byte_o     = r_byte;
    assign valid_o    = r_valid;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;
    assign busy_o     = w_busy;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
module tb_ps2_rx_ctrl;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       pulse_i = 1'b0;
    logic       data_i = 1'b1;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic       busy_o;

    always #5 clk = ~clk;

    ps2_rx_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .pulse_i    (pulse_i),
        .data_i     (data_i),
        .byte_o     (byte_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .busy_o     (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect line bits after a start bit, judge the frame
    // once all 11 bits are in, and abandon it after T silent cycles.
    logic [10:0] m_bits = '0;
    int          m_n = 0;
    int          m_silent = 0;
    logic [7:0]  m_d;
    int          m_ones;
    logic [7:0]  exp_byte = 8'h00;
    logic [1:0]  exp_code = 2'b00;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_busy = 1'b0;

    always @(posedge clk) begin
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (reset_i) begin
            m_n = 0; m_silent = 0; exp_byte = 8'h00; exp_code = 2'b00;
        end else if (pulse_i) begin
            m_silent = 0;
            if (m_n == 0) begin
                if (!data_i) begin m_bits[0] = 1'b0; m_n = 1; end
            end else begin
                m_bits[m_n] = data_i;
                m_n++;
                if (m_n == 11) begin
                    m_d    = m_bits[8:1];
                    m_ones = $countones(m_d) + int'(m_bits[9]);
                    if (!m_bits[10]) begin
                        exp_err = 1'b1; exp_code = 2'b10;
                    end else if (m_ones % 2 == 0) begin
                        exp_err = 1'b1; exp_code = 2'b01;
                    end else begin
                        exp_valid = 1'b1; exp_code = 2'b00; exp_byte = m_d;
                    end
                    m_n = 0;
                end
            end
        end else if (m_n != 0) begin
            m_silent++;
            if (m_silent >= T) begin
                exp_err = 1'b1; exp_code = 2'b11; m_n = 0; m_silent = 0;
            end
        end
        exp_busy = (m_n != 0);
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_valid",    valid_o,    exp_valid);
            check("cyc_err",      err_o,      exp_err);
            check("cyc_err_code", err_code_o, exp_code);
            check("cyc_byte",     byte_o,     exp_byte);
            check("cyc_busy",     busy_o,     exp_busy);
        end
    end

    // One line bit: pulse for one cycle, then `gap` silent cycles.
    task automatic send_bit(input logic b, input int gap);
        pulse_i = 1'b1; data_i = b;
        @(posedge clk); #1;
        pulse_i = 1'b0; data_i = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Whole frame; the stop bit has no trailing gap so the caller lands on the result cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        send_bit(stp, 0);
    endtask

    initial begin
        int n;
        logic [7:0] bits4;
        bits4 = 8'b0000_1101;

        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("rst_byte", byte_o, 8'h00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_code", err_code_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        chk_en = 1'b1;

        // Good frame 0x1C, odd parity bit 0.
        send_frame(8'h1C, 1'b0, 1'b1, 3);
        check("f1c_valid", valid_o, 1'b1);
        check("f1c_byte", byte_o, 8'h1C);
        check("f1c_code", err_code_o, 2'b00);
        repeat (2) begin @(posedge clk); #1; end

        // Same frame, wrong parity: byte must not move.
        send_frame(8'h1C, 1'b1, 1'b1, 3);
        check("par_err", err_o, 1'b1);
        check("par_code", err_code_o, 2'b01);
        check("par_byte", byte_o, 8'h1C);
        check("par_valid", valid_o, 1'b0);
        @(posedge clk); #1;
        check("par_code_hold", err_code_o, 2'b01);
        check("par_err_strobe", err_o, 1'b0);

        send_frame(8'hF0, 1'b1, 1'b1, 3);
        check("ff0_valid", valid_o, 1'b1);
        check("ff0_byte", byte_o, 8'hF0);
        check("ff0_code", err_code_o, 2'b00);

        // Bad stop bit with good parity.
        send_frame(8'h1C, 1'b0, 1'b0, 3);
        check("frm_err", err_o, 1'b1);
        check("frm_code", err_code_o, 2'b10);
        check("frm_byte", byte_o, 8'hF0);

        // Start plus 4 data bits, then silence.
        send_bit(1'b0, 3);
        for (int i = 0; i < 3; i++) send_bit(bits4[i], 3);
        send_bit(bits4[3], 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!err_o && n < 4 * T);
        check("to_edges", n, T);
        check("to_code", err_code_o, 2'b11);
        check("to_busy", busy_o, 1'b0);
        check("to_byte", byte_o, 8'hF0);
        repeat (2) begin @(posedge clk); #1; end

        send_frame(8'hAA, 1'b1, 1'b1, 3);
        check("faa_valid", valid_o, 1'b1);
        check("faa_byte", byte_o, 8'hAA);
        check("faa_code", err_code_o, 2'b00);

        // Reset after 5 data bits.
        send_bit(1'b0, 3);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 3);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        check("mr_byte", byte_o, 8'h00);
        check("mr_err", err_o, 1'b0);
        check("mr_valid", valid_o, 1'b0);
        check("mr_code", err_code_o, 2'b00);
        check("mr_busy", busy_o, 1'b0);
        repeat (3) begin @(posedge clk); #1; end

        send_frame(8'h55, 1'b1, 1'b1, 3);
        check("f55_valid", valid_o, 1'b1);
        check("f55_byte", byte_o, 8'h55);

        // A high line bit while idle is not a start bit.
        repeat (2) begin @(posedge clk); #1; end
        send_bit(1'b1, 0);
        check("idle_busy", busy_o, 1'b0);
        check("idle_err", err_o, 1'b0);
        check("idle_valid", valid_o, 1'b0);

        // Every bit lands on the terminal-count cycle: frame must survive.
        send_frame(8'h3C, 1'b1, 1'b1, T - 1);
        check("tc_valid", valid_o, 1'b1);
        check("tc_byte", byte_o, 8'h3C);
        check("tc_code", err_code_o, 2'b00);

        // One cycle more of silence than that times out.
        send_bit(1'b0, T);
        check("tb_err", err_o, 1'b1);
        check("tb_code", err_code_o, 2'b11);
        check("tb_busy", busy_o, 1'b0);

        send_frame(8'h1C, 1'b0, 1'b1, 3);
        check("last_valid", valid_o, 1'b1);
        check("last_byte", byte_o, 8'h1C);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
